// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one line-granular memory bus between two cache
// requesters (r0, r1). Round-robin arbitration on simultaneous requests,
// write/read line burst sequencing, beat relay to the granted requester and a
// memory-response timeout that aborts the transaction with an error pulse.
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   rN_cmd/addr/wdata        requester N command (1x = request, x1 = write),
//                            line address, current write beat
//   rN_grant/wnext           requester N owns the bus / write beat consumed
//   rN_rdata/rvalid          read beat relay (rdata is 0 when rvalid is 0)
//   rN_done/err              one-cycle completion pulse / timeout abort flag
//   mem_cmd/addr/wdata       memory-side command, line address, write beat
//   mem_rdata/resp           memory read beat, memory response
//   busy                     arbiter not idle
//   dbg_state_o              current FSM state (debug observation)
//
// Handshake: a requester raises cmd[1] and holds cmd/addr until it sees its
// done pulse, then drops cmd the cycle after. Requests are only sampled in
// IDLE. During a write burst wdata is consumed every cycle wnext is high and
// the next beat must be presented on the following cycle. Read beats are
// delivered on every cycle rvalid is high, without backpressure.
module mem_bus_arbiter #(
  parameter int LINE_WORDS = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  r0_cmd,
  input  logic [13:0] r0_addr,
  input  logic [15:0] r0_wdata,
  output logic        r0_grant,
  output logic        r0_wnext,
  output logic [15:0] r0_rdata,
  output logic        r0_rvalid,
  output logic        r0_done,
  output logic        r0_err,
  input  logic [1:0]  r1_cmd,
  input  logic [13:0] r1_addr,
  input  logic [15:0] r1_wdata,
  output logic        r1_grant,
  output logic        r1_wnext,
  output logic [15:0] r1_rdata,
  output logic        r1_rvalid,
  output logic        r1_done,
  output logic        r1_err,
  output logic [1:0]  mem_cmd,
  output logic [13:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_resp,
  output logic        busy,
  output logic [2:0]  dbg_state_o
);

  localparam int BW = (LINE_WORDS > 2) ? $clog2(LINE_WORDS) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(LINE_WORDS - 1);
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] WAIT_LAST = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;
  localparam bit TO_EN = (TIMEOUT > 0);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_BURST = 3'd1,
    S_WR_WAIT  = 3'd2,
    S_RD_CMD   = 3'd3,
    S_RD_WAIT  = 3'd4,
    S_RD_BURST = 3'd5,
    S_DONE     = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic            rr_q, rr_d;      // last winner; the other side wins a tie
  logic            win_q, win_d;    // requester currently owning the bus
  logic [13:0]     addr_q, addr_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            err_q, err_d;    // transaction was aborted by timeout

  logic            req0, req1, pick, pick_wr;
  logic [13:0]     pick_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b1;
      win_q   <= 1'b0;
      addr_q  <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    req0      = r0_cmd[1];
    req1      = r1_cmd[1];
    pick      = (req0 && req1) ? ~rr_q : req1;
    pick_wr   = pick ? r1_cmd[0] : r0_cmd[0];
    pick_addr = pick ? r1_addr : r0_addr;

    state_d = state_q;
    rr_d    = rr_q;
    win_d   = win_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        err_d  = 1'b0;
        beat_d = '0;
        if (req0 || req1) begin
          win_d   = pick;
          addr_d  = pick_addr;
          state_d = pick_wr ? S_WR_BURST : S_RD_CMD;
        end
      end
      S_WR_BURST: begin
        if (beat_q == BEAT_LAST) begin
          state_d = S_WR_WAIT;
          wait_d  = '0;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      S_WR_WAIT: begin
        if (mem_resp) begin
          state_d = S_DONE;
        end else if (TO_EN && (wait_q == WAIT_LAST)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_RD_CMD: begin
        state_d = S_RD_WAIT;
        wait_d  = '0;
      end
      S_RD_WAIT: begin
        // The response cycle itself carries beat 0, so the burst that
        // follows only needs LINE_WORDS-1 more beats.
        if (mem_resp) begin
          state_d = S_RD_BURST;
          beat_d  = BW'(1);
        end else if (TO_EN && (wait_q == WAIT_LAST)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_RD_BURST: begin
        if (beat_q == BEAT_LAST) begin
          state_d = S_DONE;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      rr_d = win_q;
    end
  end

  logic wr_phase, rd_beat, is_done;

  assign wr_phase = (state_q == S_WR_BURST);
  assign rd_beat  = ((state_q == S_RD_WAIT) && mem_resp) || (state_q == S_RD_BURST);
  assign is_done  = (state_q == S_DONE);
  assign busy     = (state_q != S_IDLE);

  assign mem_cmd   = wr_phase ? 2'b11 : ((state_q == S_RD_CMD) ? 2'b10 : 2'b00);
  assign mem_addr  = (wr_phase || (state_q == S_RD_CMD)) ? addr_q : '0;
  assign mem_wdata = wr_phase ? (win_q ? r1_wdata : r0_wdata) : '0;

  assign r0_grant  = busy && !win_q;
  assign r0_wnext  = wr_phase && !win_q;
  assign r0_rvalid = rd_beat && !win_q;
  assign r0_rdata  = r0_rvalid ? mem_rdata : '0;
  assign r0_done   = is_done && !win_q;
  assign r0_err    = is_done && err_q && !win_q;

  assign r1_grant  = busy && win_q;
  assign r1_wnext  = wr_phase && win_q;
  assign r1_rvalid = rd_beat && win_q;
  assign r1_rdata  = r1_rvalid ? mem_rdata : '0;
  assign r1_done   = is_done && win_q;
  assign r1_err    = is_done && err_q && win_q;

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int LW = 8;
  localparam int TO = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [1:0]  r0_cmd = '0, r1_cmd = '0;
  logic [13:0] r0_addr = '0, r1_addr = '0;
  logic [15:0] r0_wdata = '0, r1_wdata = '0;
  logic        r0_grant, r0_wnext, r0_rvalid, r0_done, r0_err;
  logic        r1_grant, r1_wnext, r1_rvalid, r1_done, r1_err;
  logic [15:0] r0_rdata, r1_rdata;
  logic [1:0]  mem_cmd;
  logic [13:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_resp;
  logic        busy;
  logic [2:0]  dbg_state;

  logic        model_resp = 1'b0;
  logic        spur_resp = 1'b0;
  assign mem_resp = model_resp | spur_resp;

  mem_bus_arbiter #(.LINE_WORDS(LW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .r0_cmd(r0_cmd), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_grant(r0_grant), .r0_wnext(r0_wnext), .r0_rdata(r0_rdata),
    .r0_rvalid(r0_rvalid), .r0_done(r0_done), .r0_err(r0_err),
    .r1_cmd(r1_cmd), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_grant(r1_grant), .r1_wnext(r1_wnext), .r1_rdata(r1_rdata),
    .r1_rvalid(r1_rvalid), .r1_done(r1_done), .r1_err(r1_err),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .busy(busy),
    .dbg_state_o(dbg_state)
  );

  // ---------------- checking infrastructure ----------------
  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Scoreboard queues.
  logic [31:0] exp_wr_q[$];  // {addr, wdata, r1_wnext, r0_wnext}
  logic [13:0] exp_rc_q[$];  // read command address
  logic [17:0] exp_rd_q[$];  // {r1_rvalid, r0_rvalid, rdata}
  logic [35:0] exp_dn_q[$];  // {r1_done, r0_done, r1_err, r0_err, cycle}

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- memory model ----------------
  int          mem_delay = 0;   // wait cycle carrying the response, 0 = never
  logic [15:0] mem_base = '0;
  logic [15:0] mem_step = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && mem_cmd == 2'b10 && mem_delay > 0) begin
        repeat (mem_delay) next_cycle();
        model_resp = 1'b1;
        mem_rdata  = mem_base;
        for (int i = 1; i < LW; i++) begin
          next_cycle();
          model_resp = 1'b0;
          mem_rdata  = 16'(mem_base + i * mem_step);
        end
        next_cycle();
        mem_rdata = '0;
      end else if (!reset && mem_cmd == 2'b11 && mem_delay > 0) begin
        repeat (LW - 1 + mem_delay) next_cycle();
        model_resp = 1'b1;
        next_cycle();
        model_resp = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic ok;
    forever begin
      @(negedge clk);
      ok = !(r0_grant && r1_grant)
        && (busy == (r0_grant || r1_grant))
        && (r0_rvalid || r0_rdata == 16'h0)
        && (r1_rvalid || r1_rdata == 16'h0)
        && (r0_grant || !(r0_wnext || r0_rvalid || r0_done || r0_err))
        && (r1_grant || !(r1_wnext || r1_rvalid || r1_done || r1_err))
        && (mem_cmd == 2'b11 || mem_wdata == 16'h0)
        && ((r0_wnext || r1_wnext) == (mem_cmd == 2'b11))
        && (mem_cmd != 2'b01)
        && (r0_done || !r0_err) && (r1_done || !r1_err);
      chk("invariants", 64'(ok), 64'd1);
      if (mem_cmd == 2'b11) begin
        if (exp_wr_q.size() == 0) chk("wr_unexpected", {mem_addr, mem_wdata}, 0);
        else chk("wr_beat", {mem_addr, mem_wdata, r1_wnext, r0_wnext}, exp_wr_q.pop_front());
      end
      if (mem_cmd == 2'b10) begin
        if (exp_rc_q.size() == 0) chk("rdcmd_unexpected", mem_addr, 64'h4000);
        else chk("rdcmd_addr", mem_addr, exp_rc_q.pop_front());
      end
      if (r0_rvalid || r1_rvalid) begin
        if (exp_rd_q.size() == 0) chk("rd_unexpected", {r1_rvalid, r0_rvalid, r0_rdata | r1_rdata}, 0);
        else chk("rd_beat", {r1_rvalid, r0_rvalid, r0_rdata | r1_rdata}, exp_rd_q.pop_front());
      end
      if (r0_done || r1_done) begin
        if (exp_dn_q.size() == 0) chk("done_unexpected", {r1_done, r0_done, r1_err, r0_err}, 0);
        else chk("done", {r1_done, r0_done, r1_err, r0_err, 32'(cyc)}, exp_dn_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  typedef struct {
    bit          id;
    bit          wr;
    logic [13:0] addr;
    logic [15:0] base;
    logic [15:0] step;
    int          dly;      // response wait cycle, 0 = memory never answers
    int          spur;     // cycle after request with a spurious mem_resp, 0 = none
    bit          exp_err;
    int          exp_lat;  // cycles from request sample to done pulse
  } txn_t;

  task automatic push_txn(bit id, bit wr, logic [13:0] addr, logic [15:0] base,
                          logic [15:0] step, int dly, int t0, bit err, int lat);
    logic [1:0] idm;
    idm = id ? 2'b10 : 2'b01;
    if (wr) begin
      for (int i = 0; i < LW; i++) exp_wr_q.push_back({addr, 16'(base + i * step), idm});
    end else begin
      exp_rc_q.push_back(addr);
      if (dly > 0)
        for (int i = 0; i < LW; i++) exp_rd_q.push_back({idm, 16'(base + i * step)});
    end
    exp_dn_q.push_back({idm, err ? idm : 2'b00, 32'(t0 + lat)});
  endtask

  task automatic set_req(bit id, logic [1:0] cmd, logic [13:0] addr, logic [15:0] wd);
    if (id) begin r1_cmd = cmd; r1_addr = addr; r1_wdata = wd; end
    else    begin r0_cmd = cmd; r0_addr = addr; r0_wdata = wd; end
  endtask

  task automatic run_txn(txn_t t);
    int j;
    bit seen;
    mem_delay = t.dly;
    mem_base  = t.base;
    mem_step  = t.step;
    push_txn(t.id, t.wr, t.addr, t.base, t.step, t.dly, cyc, t.exp_err, t.exp_lat);
    set_req(t.id, t.wr ? 2'b11 : 2'b10, t.addr, t.base);
    j = 0;
    seen = 0;
    while (!seen && j < 60) begin
      @(negedge clk);
      if (t.id ? r1_done : r0_done) seen = 1;
      next_cycle();
      j++;
      if (t.wr && j >= 1 && j <= LW) set_req(t.id, 2'b11, t.addr, 16'(t.base + (j - 1) * t.step));
      if (t.spur > 0 && j == t.spur) spur_resp = 1'b1;
      if (t.spur > 0 && j == t.spur + 1) spur_resp = 1'b0;
    end
    chk("txn_done_seen", 64'(seen), 64'd1);
    set_req(t.id, 2'b00, t.addr, 16'h0);
  endtask

  task automatic wait_dones(int n, int budget);
    int seen;
    int k;
    seen = 0;
    k = 0;
    while (seen < n && k < budget) begin
      @(negedge clk);
      if (r0_done || r1_done) seen++;
      next_cycle();
      k++;
    end
    chk("done_count", 64'(seen), 64'(n));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) next_cycle();
    reset = 1'b0;
    next_cycle();
  endtask

  // ---------------- main sequence ----------------
  txn_t tbl[9];

  initial begin
    int t0;
    tbl = '{
      '{0, 0, 14'h0123, 16'hA000, 16'h0001, 3, 0, 0, 12},
      '{1, 1, 14'h3FFF, 16'h1111, 16'h1111, 1, 0, 0, 10},
      '{0, 1, 14'h0000, 16'h0001, 16'h0001, 4, 0, 0, 13},
      '{1, 0, 14'h2AAA, 16'h5550, 16'h0003, 4, 0, 0, 13},
      '{0, 0, 14'h0042, 16'hDEAD, 16'h0001, 0, 0, 1, 6},
      '{1, 1, 14'h0100, 16'hBEEF, 16'h0101, 0, 0, 1, 13},
      '{0, 0, 14'h1234, 16'h7000, 16'h0010, 1, 0, 0, 10},
      '{1, 1, 14'h0555, 16'h0F00, 16'h0001, 2, 4, 0, 11},
      '{0, 1, 14'h1FFE, 16'hF0F0, 16'h0F0F, 1, 0, 0, 10}
    };

    // Reset state.
    repeat (2) next_cycle();
    chk("in_reset_busy", busy, 0);
    chk("in_reset_outs", {r0_grant, r0_wnext, r0_rvalid, r0_done, r0_err, r0_rdata,
                          r1_grant, r1_wnext, r1_rvalid, r1_done, r1_err, r1_rdata}, 0);
    reset = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("after_reset_mem", {mem_cmd, mem_addr, mem_wdata}, 0);
    chk("after_reset_busy", busy, 0);
    next_cycle();

    // Table-driven single-requester transactions.
    foreach (tbl[i]) run_txn(tbl[i]);

    // Spurious response while idle must not start anything.
    spur_resp = 1'b1;
    @(negedge clk);
    chk("spur_idle_busy", busy, 0);
    next_cycle();
    spur_resp = 1'b0;
    @(negedge clk);
    chk("spur_idle_after", {busy, r0_grant, r1_grant}, 0);
    next_cycle();

    // Contention from reset: both hold read requests, grants must alternate.
    do_reset();
    mem_delay = 2;
    mem_base  = 16'hC000;
    mem_step  = 16'h0001;
    t0 = cyc;
    for (int k = 0; k < 4; k++)
      push_txn(k[0], 1'b0, k[0] ? 14'h1555 : 14'h0AAA, 16'hC000, 16'h0001, 2, t0 + k * 12, 1'b0, 11);
    set_req(1'b0, 2'b10, 14'h0AAA, 16'h0);
    set_req(1'b1, 2'b10, 14'h1555, 16'h0);
    wait_dones(4, 100);
    set_req(1'b0, 2'b00, 14'h0, 16'h0);
    set_req(1'b1, 2'b00, 14'h0, 16'h0);
    next_cycle();

    // Async reset in the middle of a write burst (during beat 3).
    mem_delay = 0;
    set_req(1'b0, 2'b11, 14'h0777, 16'h4000);
    for (int i = 0; i < 4; i++) exp_wr_q.push_back({14'h0777, 16'(16'h4000 + i), 2'b01});
    for (int j = 1; j <= 4; j++) begin
      next_cycle();
      set_req(1'b0, 2'b11, 14'h0777, 16'(16'h4000 + j - 1));
    end
    #5;
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_outs", {r0_grant, r0_wnext, r0_rvalid, r0_done, r0_err, r1_grant,
                        mem_cmd, mem_addr, mem_wdata}, 0);
    set_req(1'b0, 2'b10, 14'h0101, 16'h0);
    set_req(1'b1, 2'b10, 14'h0202, 16'h0);
    mem_delay = 1;
    mem_base  = 16'h2200;
    mem_step  = 16'h0002;
    @(posedge clk);
    #1;
    reset = 1'b0;
    t0 = cyc;
    push_txn(1'b0, 1'b0, 14'h0101, 16'h2200, 16'h0002, 1, t0, 1'b0, 10);
    push_txn(1'b1, 1'b0, 14'h0202, 16'h2200, 16'h0002, 1, t0 + 11, 1'b0, 10);
    next_cycle();
    @(negedge clk);
    chk("post_rst_grant", {r1_grant, r0_grant}, 2'b01);
    wait_dones(2, 60);
    set_req(1'b0, 2'b00, 14'h0, 16'h0);
    set_req(1'b1, 2'b00, 14'h0, 16'h0);
    repeat (3) next_cycle();

    chk("wr_q_empty", exp_wr_q.size(), 0);
    chk("rc_q_empty", exp_rc_q.size(), 0);
    chk("rd_q_empty", exp_rd_q.size(), 0);
    chk("dn_q_empty", exp_dn_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
